// File: rtl/muldiv_engine.sv
// ============================================================================
// Module   : muldiv_engine
// Purpose  : Iterative 32-cycle shift-add multiplier / restoring divider
//            driving the HI/LO pair with a stall/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             cpu_stall,
  output logic             stallForcc,
  output logic             overForcc,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [1:0]       ST_IDLE   = 2'd0;
  localparam logic [1:0]       ST_MUL    = 2'd1;
  localparam logic [1:0]       ST_DIV    = 2'd2;
  localparam logic [1:0]       ST_DONE   = 2'd3;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               w_signed, w_sa, w_sb;
  logic               w_accept, w_div0, w_busy, w_last, w_qbit;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem;
  logic [WIDTH:0]     w_madd, w_dshift, w_ddiff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;

  assign w_signed = ~op[0];
  assign w_sa     = w_signed & a[WIDTH-1];
  assign w_sb     = w_signed & b[WIDTH-1];
  assign w_mag_a  = w_sa ? -a : a;
  assign w_mag_b  = w_sb ? -b : b;

  assign w_busy   = (state_q == ST_MUL) | (state_q == ST_DIV);
  assign w_accept = (state_q == ST_IDLE) & start & ~flush;
  assign w_div0   = op[1] & (b == '0);
  assign w_last   = w_busy & (cnt_q == LAST_ITER);

  // Shift-add: upper half accumulates the multiplicand, multiplier drains out the bottom.
  assign w_madd     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign w_mul_next = {w_madd, acc_q[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_dshift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_ddiff    = w_dshift - {1'b0, opb_q};
  assign w_qbit     = ~w_ddiff[WIDTH];
  assign w_div_next = {(w_qbit ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], w_qbit};

  assign w_prod = neg_q  ? -w_mul_next : w_mul_next;
  assign w_quo  = neg_q  ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
  assign w_rem  = rneg_q ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (w_div0) begin
              state_d = ST_DONE;
            end else if (op[1]) begin
              state_d = ST_DIV;
            end else begin
              state_d = ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_last) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = cpu_stall ? ST_DONE : ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stallForcc = w_accept | w_busy;
    overForcc  = (state_q == ST_DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opb_d  = opb_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (flush) begin
      cnt_d = '0;
    end else if (w_accept) begin
      cnt_d  = '0;
      acc_d  = {{WIDTH{1'b0}}, w_mag_a};
      opb_d  = w_mag_b;
      neg_d  = w_sa ^ w_sb;
      rneg_d = w_sa;
      if (w_div0) begin
        hi_d = a;
        lo_d = '1;
      end
    end else if (w_busy) begin
      acc_d = (state_q == ST_MUL) ? w_mul_next : w_div_next;
      cnt_d = w_last ? '0 : cnt_q + CNT_W'(1);
      if (w_last) begin
        if (state_q == ST_MUL) begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end else begin
          hi_d = w_rem;
          lo_d = w_quo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opb_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_engine.sv
// ============================================================================
// Module   : tb_muldiv_engine
// Purpose  : Randomized and directed self-checking bench for muldiv_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        cpu_stall;
  logic        stallForcc;
  logic        overForcc;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_engine #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .cpu_stall  (cpu_stall),
    .stallForcc (stallForcc),
    .overForcc  (overForcc),
    .HI         (HI),
    .LO         (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   p = sx * sy;
      2'b01:   p = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) begin
          p = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {x % y, x / y};
        end
      end
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation; start stays high through DONE, cpu_stall held for 'hold' DONE cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold);
    logic [63:0] exp, prev;
    int          lat, exp_lat;
    bit          stall_ok, stable, held_ok;
    exp     = ref_result(o, x, y);
    exp_lat = (o[1] && y == 32'd0) ? 1 : 33;
    tick();
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    chk_val("stall_c0", stallForcc, 1);
    prev = {HI, LO};
    stall_ok = 1; stable = 1; lat = 0;
    do begin
      tick();
      lat++;
      a = $urandom; b = $urandom;
      @(negedge clk);
      if (overForcc !== 1'b1) begin
        if (stallForcc !== 1'b1) stall_ok = 0;
        if ({HI, LO} !== prev) stable = 0;
      end
    end while (overForcc !== 1'b1 && lat < 40);
    chk_val("latency", lat, exp_lat);
    chk_val("stall_busy", stall_ok, 1);
    chk_val("hilo_hold", stable, 1);
    chk_val("stall_done", stallForcc, 0);
    chk_val("result", {HI, LO}, exp);
    held_ok = 1;
    cpu_stall = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (i == hold - 1) cpu_stall = 1'b0;
      @(negedge clk);
      if (overForcc !== 1'b1 || {HI, LO} !== exp) held_ok = 0;
    end
    if (hold > 0) chk_val("done_held", held_ok, 1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk_val("exit_over", overForcc, 0);
    chk_val("exit_stall", stallForcc, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          seen_over;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0; cpu_stall = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk_val("rst_stall", stallForcc, 0);
    chk_val("rst_over", overForcc, 0);
    chk_val("rst_hilo", {HI, LO}, 64'd0);
    tick();
    rst = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd100, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'h0000_2211, 32'h0000_0100, 0);

    // Flush mid-multiply must leave HI/LO untouched and never signal completion.
    tick();
    start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd9;
    repeat (10) tick();
    flush = 1'b1; start = 1'b0;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk_val("flush_stall", stallForcc, 0);
    seen_over = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (overForcc === 1'b1) seen_over = 1;
    end
    chk_val("flush_no_over", seen_over, 0);
    chk_val("flush_hilo", {HI, LO}, 64'h0000_0011_0000_0022);

    run_op(2'b01, 32'd7, 32'd9, 0);
    run_op(2'b01, 32'd3, 32'd4, 2);

    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'd1;
        3: rb = 32'($urandom_range(1, 255));
        default: ;
      endcase
      run_op(ro, ra, rb, int'($urandom_range(0, 2)));
    end

    run_op(2'b11, 32'h0000_2211, 32'h0000_0100, 0);

    // Reset in the middle of a divide: synchronous, so nothing changes before the edge.
    tick();
    start = 1'b1; op = 2'b10; a = 32'h1234_5678; b = 32'd13;
    repeat (15) tick();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_val("rst_sync_stall", stallForcc, 1);
    chk_val("rst_sync_hilo", {HI, LO}, 64'h0000_0011_0000_0022);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk_val("midrst_stall", stallForcc, 0);
    chk_val("midrst_over", overForcc, 0);
    chk_val("midrst_hilo", {HI, LO}, 64'd0);

    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
